bsg_counter_limit_loader: RTL and testbench

Upstream limit-management stage for `bsg_counter_dynamic_limit`. It accepts new limit values over a valid/ready handshake and holds each in a shadow register. It drives the counter's `limit_i` and changes it only at the counter's wrap point, so every count period runs to completion under a single, stable limit. It also reports wrap events, pending updates and a commit epoch to the control logic.

---
 rtl/bsg_counter_limit_loader_pkg.sv | 13 +
 rtl/bsg_counter_dynamic_limit.sv | 29 ++
 rtl/bsg_dff_reset_en.sv | 30 +++
 rtl/bsg_counter_limit_loader.sv | 105 ++++++++++
 tb/tb_bsg_counter_limit_loader.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_counter_limit_loader_pkg.sv
// rtl/bsg_counter_limit_loader_pkg.sv - shared types for the limit loader
//
// Purpose: state encoding shared by the limit loader and anything that
// wants to decode its state.
package bsg_counter_limit_loader_pkg;

  // IDLE: ready for a new limit. PENDING: a shadow limit waits for a wrap.
  typedef enum logic {
    e_idle    = 1'b0,
    e_pending = 1'b1
  } bsg_cll_state_e;

endpackage

// File: rtl/bsg_counter_dynamic_limit.sv
// rtl/bsg_counter_dynamic_limit.sv - free-running counter that wraps at limit_i
//
// Purpose: counts 0..limit_i and returns to 0 on the edge after
// counter_o == limit_i. Reset is synchronous.
// Ports:
//   clk_i      in   clock
//   reset_i    in   synchronous active-high reset
//   limit_i    in   inclusive wrap value
//   counter_o  out  current count
module bsg_counter_dynamic_limit #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] limit_i,
  output logic [width_p-1:0] counter_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      counter_o <= '0;
    end else if (counter_o == limit_i) begin
      counter_o <= '0;
    end else begin
      counter_o <= counter_o + width_p'(1);
    end
  end

endmodule

// File: rtl/bsg_dff_reset_en.sv
// rtl/bsg_dff_reset_en.sv - enabled register with asynchronous reset value
//
// Purpose: width_p-bit register that loads data_i when en_i is high and
// returns to reset_val_p asynchronously on reset_i.
// Ports:
//   clk_i    in   clock
//   reset_i  in   asynchronous active-high reset
//   en_i     in   load enable
//   data_i   in   next value
//   data_o   out  registered value
module bsg_dff_reset_en #(
  parameter int                 width_p     = 8,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_o <= reset_val_p;
    end else if (en_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/bsg_counter_limit_loader.sv
// rtl/bsg_counter_limit_loader.sv - shadowed limit loader for a dynamic-limit counter
//
// Purpose: accepts new limits over valid/ready, holds them in a shadow
// register and applies them to limit_o only when the downstream counter
// wraps, so each count period runs under one stable limit.
// Ports:
//   clk_i         in   clock
//   reset_i       in   asynchronous active-high reset
//   v_i           in   new limit offered
//   limit_data_i  in   offered limit value
//   ready_o       out  a limit can be accepted this cycle
//   counter_i     in   count of the downstream counter
//   limit_o       out  limit driven to the downstream counter
//   wrap_o        out  counter_i == limit_o (combinational)
//   pending_o     out  a shadow limit waits for a wrap
//   commit_o      out  limit_o changed at the previous edge
//   epoch_o       out  number of commits, modulo 2^epoch_width_p
module bsg_counter_limit_loader
  import bsg_counter_limit_loader_pkg::*;
#(
  parameter int                 width_p       = 128,
  parameter logic [width_p-1:0] init_limit_p  = '0,
  parameter int                 epoch_width_p = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic [width_p-1:0]       limit_data_i,
  output logic                     ready_o,
  input  logic [width_p-1:0]       counter_i,
  output logic [width_p-1:0]       limit_o,
  output logic                     wrap_o,
  output logic                     pending_o,
  output logic                     commit_o,
  output logic [epoch_width_p-1:0] epoch_o
);

  bsg_cll_state_e     state_r;
  logic               commit_r;
  logic [width_p-1:0] shadow_r;
  logic               accept;
  logic               limit_en;
  logic               shadow_en;
  logic [width_p-1:0] limit_n;

  assign ready_o   = (state_r == e_idle);
  assign pending_o = (state_r == e_pending);
  assign commit_o  = commit_r;
  assign wrap_o    = (counter_i == limit_o);
  assign accept    = v_i & ready_o;

  // A limit moves to limit_o only on a wrap: either the waiting shadow, or
  // a fresh offer that lands exactly on a wrap cycle (bypass).
  assign limit_en  = wrap_o & (pending_o | accept);
  assign shadow_en = accept & ~wrap_o;
  assign limit_n   = pending_o ? shadow_r : limit_data_i;

  bsg_dff_reset_en #(
    .width_p    (width_p),
    .reset_val_p(init_limit_p)
  ) limit_reg (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (limit_en),
    .data_i (limit_n),
    .data_o (limit_o)
  );

  bsg_dff_reset_en #(
    .width_p    (width_p),
    .reset_val_p('0)
  ) shadow_reg (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (shadow_en),
    .data_i (limit_data_i),
    .data_o (shadow_r)
  );

  bsg_dff_reset_en #(
    .width_p    (epoch_width_p),
    .reset_val_p('0)
  ) epoch_reg (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (limit_en),
    .data_i (epoch_o + epoch_width_p'(1)),
    .data_o (epoch_o)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r  <= e_idle;
      commit_r <= 1'b0;
    end else begin
      commit_r <= limit_en;
      case (state_r)
        e_idle:    if (shadow_en) state_r <= e_pending;
        e_pending: if (wrap_o)    state_r <= e_idle;
        default:                  state_r <= e_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_counter_limit_loader.sv
// tb/tb_bsg_counter_limit_loader.sv - self-checking bench for the limit loader
module tb_bsg_counter_limit_loader;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       v_i;
  logic [7:0] limit_data_i;
  logic       ready_o;
  logic [7:0] counter;
  logic [7:0] limit_o;
  logic       wrap_o;
  logic       pending_o;
  logic       commit_o;
  logic [7:0] epoch_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bsg_counter_limit_loader #(
    .width_p      (8),
    .init_limit_p (8'd4),
    .epoch_width_p(8)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .v_i         (v_i),
    .limit_data_i(limit_data_i),
    .ready_o     (ready_o),
    .counter_i   (counter),
    .limit_o     (limit_o),
    .wrap_o      (wrap_o),
    .pending_o   (pending_o),
    .commit_o    (commit_o),
    .epoch_o     (epoch_o)
  );

  bsg_counter_dynamic_limit #(.width_p(8)) cnt (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .limit_i  (limit_o),
    .counter_o(counter)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] cnt;
    logic [7:0] lim;
    logic       rdy;
    logic       pend;
    logic       com;
    logic [7:0] ep;
  } vec_t;

  vec_t tbl[20];

  // Reference model state for the random phase.
  int m_limit, m_shadow, m_counter, m_epoch;
  bit m_pending, m_commit;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [7:0] c,
                              input logic [7:0] l, input logic r, input logic p,
                              input logic cm, input logic [7:0] e);
    vec_t x;
    x.v = v; x.d = d; x.cnt = c; x.lim = l; x.rdy = r; x.pend = p; x.com = cm; x.ep = e;
    return x;
  endfunction

  // One clock of the limit rules: a waiting limit lands on a wrap; an offer
  // in idle lands at once on a wrap, else waits.
  task automatic model_edge(input bit v, input int d);
    bit w;
    w = (m_counter == m_limit);
    m_commit = 0;
    if (m_pending) begin
      if (w) begin
        m_limit = m_shadow; m_pending = 0; m_commit = 1;
      end
    end else if (v) begin
      if (w) begin
        m_limit = d; m_commit = 1;
      end else begin
        m_shadow = d; m_pending = 1;
      end
    end
    m_counter = w ? 0 : m_counter + 1;
    m_epoch   = (m_epoch + int'(m_commit)) % 256;
  endtask

  initial begin
    reset_i = 1'b0;
    v_i = 1'b0;
    limit_data_i = 8'd0;

    //         v  d  cnt lim rdy pnd com ep
    tbl[0]  = mk(0, 0, 1, 4, 1, 0, 0, 0);
    tbl[1]  = mk(1, 2, 2, 4, 0, 1, 0, 0);
    tbl[2]  = mk(0, 0, 3, 4, 0, 1, 0, 0);
    tbl[3]  = mk(0, 0, 4, 4, 0, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 2, 1, 0, 1, 1);
    tbl[5]  = mk(0, 0, 1, 2, 1, 0, 0, 1);
    tbl[6]  = mk(0, 0, 2, 2, 1, 0, 0, 1);
    tbl[7]  = mk(1, 6, 0, 6, 1, 0, 1, 2);
    tbl[8]  = mk(1, 2, 1, 6, 0, 1, 0, 2);
    tbl[9]  = mk(1, 7, 2, 6, 0, 1, 0, 2);
    tbl[10] = mk(1, 7, 3, 6, 0, 1, 0, 2);
    tbl[11] = mk(1, 7, 4, 6, 0, 1, 0, 2);
    tbl[12] = mk(1, 7, 5, 6, 0, 1, 0, 2);
    tbl[13] = mk(1, 7, 6, 6, 0, 1, 0, 2);
    tbl[14] = mk(1, 7, 0, 2, 1, 0, 1, 3);
    tbl[15] = mk(1, 7, 1, 2, 0, 1, 0, 3);
    tbl[16] = mk(0, 0, 2, 2, 0, 1, 0, 3);
    tbl[17] = mk(0, 0, 0, 7, 1, 0, 1, 4);
    tbl[18] = mk(0, 0, 1, 7, 1, 0, 0, 4);
    tbl[19] = mk(1, 9, 2, 7, 0, 1, 0, 4);

    // Reset asserted between edges takes effect immediately.
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    chk("rst_limit", limit_o, 4);
    chk("rst_ready", ready_o, 1);
    chk("rst_pending", pending_o, 0);
    chk("rst_commit", commit_o, 0);
    chk("rst_epoch", epoch_o, 0);
    tick();
    reset_i = 1'b0;
    chk("rst_counter", counter, 0);

    // Deferred commit, bypass, backpressure, then a pending accept of 9.
    for (int i = 0; i < 20; i++) begin
      v_i = tbl[i].v;
      limit_data_i = tbl[i].d;
      tick();
      chk($sformatf("t%0d_counter", i), counter, tbl[i].cnt);
      chk($sformatf("t%0d_limit", i), limit_o, tbl[i].lim);
      chk($sformatf("t%0d_ready", i), ready_o, tbl[i].rdy);
      chk($sformatf("t%0d_pending", i), pending_o, tbl[i].pend);
      chk($sformatf("t%0d_commit", i), commit_o, tbl[i].com);
      chk($sformatf("t%0d_epoch", i), epoch_o, tbl[i].ep);
    end
    v_i = 1'b0;

    // Reset mid-pending: shadow 9 is discarded.
    reset_i = 1'b1;
    #1;
    chk("mid_rst_limit", limit_o, 4);
    chk("mid_rst_pending", pending_o, 0);
    chk("mid_rst_commit", commit_o, 0);
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_limit", limit_o, 4);
      chk("post_rst_commit", commit_o, 0);
      chk("post_rst_epoch", epoch_o, 0);
    end

    // Limit 0: commit it on a wrap, then commit 0 every cycle.
    begin
      int budget;
      budget = 0;
      while (!wrap_o && budget < 10) begin
        tick();
        budget++;
      end
      if (!wrap_o) chk("wait_wrap_timeout", 0, 1);
    end
    v_i = 1'b1;
    limit_data_i = 8'd0;
    tick();
    chk("zero_limit", limit_o, 0);
    chk("zero_commit", commit_o, 1);
    chk("zero_epoch", epoch_o, 1);
    for (int i = 1; i < 256; i++) begin
      tick();
      chk("b2b_commit", commit_o, 1);
      chk("b2b_pending", pending_o, 0);
      chk("b2b_epoch", epoch_o, (i + 1) % 256);
    end
    chk("epoch_wrapped", epoch_o, 0);
    v_i = 1'b0;

    // Random traffic against the reference model, from a fresh reset.
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    m_limit = 4; m_shadow = 0; m_counter = 0; m_epoch = 0;
    m_pending = 0; m_commit = 0;
    for (int i = 0; i < 1500; i++) begin
      v_i = 1'($urandom_range(0, 1));
      limit_data_i = 8'($urandom_range(0, 7));
      #1;
      chk("rnd_wrap", wrap_o, int'(m_counter == m_limit));
      chk("rnd_ready", ready_o, int'(!m_pending));
      model_edge(v_i, int'(limit_data_i));
      tick();
      chk("rnd_counter", counter, m_counter);
      chk("rnd_limit", limit_o, m_limit);
      chk("rnd_pending", pending_o, int'(m_pending));
      chk("rnd_commit", commit_o, int'(m_commit));
      chk("rnd_epoch", epoch_o, m_epoch);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
